// File: rtl/nn_wb_ctrl_if.sv
// Register-bus signals between a Wishbone-style master and the NN core front-end.
interface nn_wb_ctrl_if;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wren;
  logic        rden;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (output wbs_adr_i, wbs_dat_i, wren, rden,
                  input  wbs_ack_o, wbs_dat_o);
  modport slave  (input  wbs_adr_i, wbs_dat_i, wren, rden,
                  output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/nn_wb_ctrl.sv
// Bus front-end and run sequencer for the NN core: operand/control registers,
// launch FSM with timeout, result FIFO, latency capture and interrupt.
//
//  state  | meaning
//  IDLE   | waiting for a start request
//  FIRE   | one-cycle launch strobe to the core
//  WAIT   | counting cycles until a core result or timeout
module nn_wb_ctrl #(
  parameter int          N_IN       = 2,
  parameter int          FIFO_DEPTH = 4,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic               clk,
  input  logic               rst_l,
  nn_wb_ctrl_if.slave        bus,
  input  logic               in_valid_user,
  output logic [32*N_IN-1:0] op_o,
  output logic [2:0]         round_mode_o,
  output logic               core_in_valid_o,
  input  logic               core_out_valid_i,
  input  logic [31:0]        core_result_i,
  output logic               irq_o
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_WAIT} state_t;

  state_t          r_state, w_state_nx;
  logic [31:0]     r_op [N_IN];
  logic [2:0]      r_round;
  logic            r_irq_en;
  logic            r_ovf, r_tmo, r_rej;
  logic [15:0]     r_cnt, r_lat;
  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [CW-1:0]   r_count;
  logic            r_ack;
  logic [31:0]     r_rdata;

  logic [7:0]  w_off;
  logic        w_in_win, w_wr, w_rd, w_busy, w_start, w_rej;
  logic        w_empty, w_full, w_pop, w_push_req, w_push, w_ovf, w_timeout;
  logic [31:0] w_rdata, w_status;

  assign w_in_win   = (bus.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_off      = bus.wbs_adr_i[7:0];
  assign w_wr       = bus.wren & w_in_win;
  assign w_rd       = bus.rden & ~bus.wren & w_in_win;
  assign w_busy     = (r_state != S_IDLE);
  assign w_start    = in_valid_user | (w_wr & (w_off == 8'h40) & bus.wbs_dat_i[0]);
  assign w_rej      = w_start & w_busy;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_pop      = w_rd & (w_off == 8'h48) & ~w_empty;
  assign w_push_req = (r_state == S_WAIT) & core_out_valid_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf      = w_push_req & w_full & ~w_pop;
  assign w_timeout  = (r_state == S_WAIT) & ~core_out_valid_i & (r_cnt == 16'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx      = r_state;
    core_in_valid_o = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_start) w_state_nx = S_FIRE;
      S_FIRE: begin
        core_in_valid_o = 1'b1;
        w_state_nx      = S_WAIT;
      end
      S_WAIT: if (core_out_valid_i || w_timeout) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_cnt <= '0;
      r_lat <= '0;
    end else begin
      // First WAIT cycle counts as 1 so LAT equals cycles since FIRE.
      if (r_state == S_FIRE)      r_cnt <= 16'd1;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 16'd1;
      else                        r_cnt <= '0;
      if (w_push_req) r_lat <= r_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < N_IN; i++) r_op[i] <= '0;
      r_round  <= '0;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_tmo    <= 1'b0;
      r_rej    <= 1'b0;
    end else begin
      for (int i = 0; i < N_IN; i++)
        if (w_wr && !w_busy && (w_off == 8'(4*i))) r_op[i] <= bus.wbs_dat_i;
      if (w_wr && (w_off == 8'h40)) begin
        r_irq_en <= bus.wbs_dat_i[4];
        if (!w_busy) r_round <= bus.wbs_dat_i[3:1];
      end
      r_ovf <= w_ovf     | (r_ovf & ~(w_wr & (w_off == 8'h44) & bus.wbs_dat_i[3]));
      r_tmo <= w_timeout | (r_tmo & ~(w_wr & (w_off == 8'h44) & bus.wbs_dat_i[4]));
      r_rej <= w_rej     | (r_rej & ~(w_wr & (w_off == 8'h44) & bus.wbs_dat_i[5]));
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= core_result_i;
  end

  assign w_status = {19'b0, 5'(r_count), 2'b0, r_rej, r_tmo, r_ovf, w_full, w_empty, w_busy};

  always_comb begin
    w_rdata = '0;
    case (w_off)
      8'h40:   w_rdata = {27'b0, r_irq_en, r_round, 1'b0};
      8'h44:   w_rdata = w_status;
      8'h48:   w_rdata = w_empty ? 32'h0 : r_mem[r_rp];
      8'h4C:   w_rdata = {16'b0, r_lat};
      default: begin
        for (int i = 0; i < N_IN; i++)
          if (w_off == 8'(4*i)) w_rdata = r_op[i];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_wr | w_rd;
      r_rdata <= w_rd ? w_rdata : 32'h0;
    end
  end

  assign bus.wbs_ack_o = r_ack;
  assign bus.wbs_dat_o = r_rdata;

  for (genvar g = 0; g < N_IN; g++) begin : g_op
    assign op_o[32*g +: 32] = r_op[g];
  end

  assign round_mode_o = r_round;
  assign irq_o        = r_irq_en & (~w_empty | r_tmo | r_ovf);
endmodule
